// File: rtl/press_pkg.sv
// ============================================================================
// Module      : press_pkg
// Description : Shared state encodings and default timing limits for the
//               press classifier and its timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package press_pkg;

  // Classifier FSM state encodings
  typedef enum logic [2:0] {
    IDLE           = 3'd0,
    PRESSED        = 3'd1,
    WAIT_SECOND    = 3'd2,
    SECOND_PRESSED = 3'd3,
    LONG_HELD      = 3'd4
  } press_state_t;

  // Default limits, in i_Clk cycles at 25 MHz
  localparam int unsigned c_DEF_LONG_LIMIT    = 12500000;  // 500 ms
  localparam int unsigned c_DEF_DOUBLE_GAP    = 6250000;   // 250 ms
  localparam int unsigned c_DEF_REPEAT_PERIOD = 2500000;   // 100 ms
  localparam int unsigned c_DEF_CNT_WIDTH     = 24;

endpackage : press_pkg

`default_nettype wire

// File: rtl/press_timer.sv
// ============================================================================
// Module      : press_timer
// Description : Up-counter with synchronous clear and count enable, plus a
//               terminal-count compare against a caller-selected value.
//               Clear wins over enable.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_timer #(
  parameter int unsigned c_CNT_WIDTH = 24
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  input  logic                   i_Clear,
  input  logic                   i_Enable,
  input  logic [c_CNT_WIDTH-1:0] i_Terminal_Count,
  output logic                   o_Terminal
);

  logic [c_CNT_WIDTH-1:0] r_Count;

  // Counter: reset/clear to zero, otherwise advance when enabled
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L || i_Clear) begin
      r_Count <= '0;
    end else if (i_Enable) begin
      r_Count <= r_Count + c_CNT_WIDTH'(1);
    end
  end

  assign o_Terminal = (r_Count == i_Terminal_Count);

endmodule : press_timer

`default_nettype wire

// File: rtl/press_classifier.sv
// ============================================================================
// Module      : press_classifier
// Description : Classifies debounced switch presses as short, long or double
//               and emits one-cycle, mutually exclusive event pulses plus a
//               held level while a long press persists.
//               Optional macro PRESS_REPEAT_EN: auto-repeat o_Long_Press every
//               c_REPEAT_PERIOD cycles while in LONG_HELD.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned c_LONG_LIMIT    = c_DEF_LONG_LIMIT,
  parameter int unsigned c_DOUBLE_GAP    = c_DEF_DOUBLE_GAP,
  parameter int unsigned c_REPEAT_PERIOD = c_DEF_REPEAT_PERIOD,
  parameter int unsigned c_CNT_WIDTH     = c_DEF_CNT_WIDTH
) (
  input  logic i_Clk,
  input  logic i_Rst_L,
  input  logic i_Switch,
  output logic o_Short_Press,
  output logic o_Long_Press,
  output logic o_Double_Press,
  output logic o_Held
);

  // Terminal-count values: a limit of N cycles ends when the count shows N-1
  localparam logic [c_CNT_WIDTH-1:0] c_LONG_TC   = c_CNT_WIDTH'(c_LONG_LIMIT - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_GAP_TC    = c_CNT_WIDTH'(c_DOUBLE_GAP - 1);
  localparam logic [c_CNT_WIDTH-1:0] c_REPEAT_TC = c_CNT_WIDTH'(c_REPEAT_PERIOD - 1);

  press_state_t           r_State;
  logic                   r_Prev;
  logic                   r_Short;
  logic                   r_Long;
  logic                   r_Double;
  logic                   r_Held;

  logic                   w_rise;
  logic                   w_fall;
  logic                   w_timer_clear;
  logic                   w_timer_en;
  logic                   w_timer_term;
  logic [c_CNT_WIDTH-1:0] w_timer_tc;

  assign w_rise = i_Switch & ~r_Prev;
  assign w_fall = ~i_Switch & r_Prev;

  // Timer control: count only while staying in a timed state, clear on any
  // state change so the count always starts from zero in the new state
  always_comb begin
    w_timer_clear = 1'b1;
    w_timer_en    = 1'b0;
    w_timer_tc    = c_LONG_TC;
    case (r_State)
      PRESSED: begin
        w_timer_tc = c_LONG_TC;
        if (i_Switch && !w_timer_term) begin
          w_timer_clear = 1'b0;
          w_timer_en    = 1'b1;
        end
      end
      WAIT_SECOND: begin
        w_timer_tc = c_GAP_TC;
        if (!w_rise && !w_timer_term) begin
          w_timer_clear = 1'b0;
          w_timer_en    = 1'b1;
        end
      end
      LONG_HELD: begin
        w_timer_tc = c_REPEAT_TC;
`ifdef PRESS_REPEAT_EN
        if (i_Switch && !w_timer_term) begin
          w_timer_clear = 1'b0;
          w_timer_en    = 1'b1;
        end
`endif
      end
      default: begin
        w_timer_clear = 1'b1;
        w_timer_en    = 1'b0;
      end
    endcase
  end

  press_timer #(
    .c_CNT_WIDTH (c_CNT_WIDTH)
  ) u_press_timer (
    .i_Clk            (i_Clk),
    .i_Rst_L          (i_Rst_L),
    .i_Clear          (w_timer_clear),
    .i_Enable         (w_timer_en),
    .i_Terminal_Count (w_timer_tc),
    .o_Terminal       (w_timer_term)
  );

  // Classification FSM with registered pulse and level outputs
  always_ff @(posedge i_Clk) begin
    if (!i_Rst_L) begin
      r_State  <= IDLE;
      r_Prev   <= 1'b0;
      r_Short  <= 1'b0;
      r_Long   <= 1'b0;
      r_Double <= 1'b0;
      r_Held   <= 1'b0;
    end else begin
      r_Prev   <= i_Switch;
      r_Short  <= 1'b0;
      r_Long   <= 1'b0;
      r_Double <= 1'b0;
      r_Held   <= 1'b0;
      case (r_State)
        IDLE: begin
          if (w_rise) begin
            r_State <= PRESSED;
          end
        end
        PRESSED: begin
          if (w_fall) begin
            r_State <= WAIT_SECOND;
          end else if (w_timer_term) begin
            r_State <= LONG_HELD;
            r_Long  <= 1'b1;
            r_Held  <= 1'b1;
          end
        end
        WAIT_SECOND: begin
          // A rise on the expiry cycle still counts as a double press
          if (w_rise) begin
            r_State  <= SECOND_PRESSED;
            r_Double <= 1'b1;
          end else if (w_timer_term) begin
            r_State <= IDLE;
            r_Short <= 1'b1;
          end
        end
        SECOND_PRESSED: begin
          if (w_fall) begin
            r_State <= IDLE;
          end
        end
        LONG_HELD: begin
          if (w_fall) begin
            r_State <= IDLE;
          end else begin
            r_Held <= 1'b1;
`ifdef PRESS_REPEAT_EN
            if (w_timer_term) begin
              r_Long <= 1'b1;
            end
`endif
          end
        end
        default: begin
          r_State <= IDLE;
        end
      endcase
    end
  end

  assign o_Short_Press  = r_Short;
  assign o_Long_Press   = r_Long;
  assign o_Double_Press = r_Double;
  assign o_Held         = r_Held;

endmodule : press_classifier

`default_nettype wire

// File: tb/tb_press_classifier.sv
// ============================================================================
// Module      : tb_press_classifier
// Description : Directed testbench for press_classifier with small limits
//               (long 10, gap 5, repeat 4). Cycle c is the clock edge at which
//               the stimulus for c is sampled; outputs checked at cycle c are
//               those registered on the previous edge.
//               Honours PRESS_REPEAT_EN for the expected long-press pattern.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_press_classifier;

  logic i_Clk;
  logic i_Rst_L;
  logic i_Switch;
  logic o_Short_Press;
  logic o_Long_Press;
  logic o_Double_Press;
  logic o_Held;

  int n_compared;
  int n_mismatched;

  press_classifier #(
    .c_LONG_LIMIT    (10),
    .c_DOUBLE_GAP    (5),
    .c_REPEAT_PERIOD (4),
    .c_CNT_WIDTH     (24)
  ) dut (
    .i_Clk          (i_Clk),
    .i_Rst_L        (i_Rst_L),
    .i_Switch       (i_Switch),
    .o_Short_Press  (o_Short_Press),
    .o_Long_Press   (o_Long_Press),
    .o_Double_Press (o_Double_Press),
    .o_Held         (o_Held)
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  // Hold reset with the switch released for a few edges
  task automatic apply_reset();
    i_Rst_L  = 1'b0;
    i_Switch = 1'b0;
    repeat (3) @(negedge i_Clk);
  endtask

  // Outputs come straight out of reset as zero
  task automatic test_reset();
    logic [3:0] got;
    apply_reset();
    got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
    n_compared++;
    if (got !== 4'b0000) begin
      n_mismatched++;
      $display("FAIL reset_state: got {S,L,D,H}=%b, want 0000", got);
    end
  endtask

  // Rise 0, fall 3, no second press: short at 9 only
  task automatic test_short_press();
    logic [3:0] got, exp;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge i_Clk);
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = {(c == 9), 1'b0, 1'b0, 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL short_press cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = 1'b1;
      i_Switch = (c < 3);
    end
  endtask

  // Rise 0, held through cycle 29, fall 30: long at 11 (repeats if enabled),
  // held 11..30, nothing on release
  task automatic test_long_press();
    logic [3:0] got, exp;
    logic       exp_long;
    apply_reset();
    for (int c = 0; c < 45; c++) begin
      @(negedge i_Clk);
`ifdef PRESS_REPEAT_EN
      exp_long = (c >= 11) && (c <= 27) && (((c - 11) % 4) == 0);
`else
      exp_long = (c == 11);
`endif
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = {1'b0, exp_long, 1'b0, ((c >= 11) && (c <= 30))};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL long_press cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = 1'b1;
      i_Switch = (c < 30);
    end
  endtask

  // Rise 0, fall 3, rise 6 held 20 cycles: double at 7, no long or short
  task automatic test_double_press();
    logic [3:0] got, exp;
    apply_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge i_Clk);
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = {1'b0, 1'b0, (c == 7), 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL double_press cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = 1'b1;
      i_Switch = (c < 3) || ((c >= 6) && (c < 26));
    end
  endtask

  // Second rise exactly on the gap expiry cycle (8): double at 9, no short
  task automatic test_gap_expiry_edge();
    logic [3:0] got, exp;
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge i_Clk);
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = {1'b0, 1'b0, (c == 9), 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL gap_expiry_edge cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = 1'b1;
      i_Switch = (c < 3) || ((c >= 8) && (c < 12));
    end
  endtask

  // Second rise one cycle late (9): short at 9, then a fresh press
  // (rise 9, fall 12) gives another short at 18
  task automatic test_gap_just_missed();
    logic [3:0] got, exp;
    apply_reset();
    for (int c = 0; c < 25; c++) begin
      @(negedge i_Clk);
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = {((c == 9) || (c == 18)), 1'b0, 1'b0, 1'b0};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL gap_just_missed cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = 1'b1;
      i_Switch = (c < 3) || ((c >= 9) && (c < 12));
    end
  endtask

  // Reset at 5..6 with switch held: press restarts at 7, long at 18
  task automatic test_reset_mid_press();
    logic [3:0] got, exp;
    logic       exp_long;
    apply_reset();
    for (int c = 0; c < 36; c++) begin
      @(negedge i_Clk);
`ifdef PRESS_REPEAT_EN
      exp_long = (c >= 18) && (((c - 18) % 4) == 0);
`else
      exp_long = (c == 18);
`endif
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = {1'b0, exp_long, 1'b0, (c >= 18)};
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL reset_mid_press cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = !((c == 5) || (c == 6));
      i_Switch = 1'b1;
    end
  endtask

  // Reset during the gap abandons the pending short press
  task automatic test_reset_pending_short();
    logic [3:0] got, exp;
    apply_reset();
    for (int c = 0; c < 20; c++) begin
      @(negedge i_Clk);
      got = {o_Short_Press, o_Long_Press, o_Double_Press, o_Held};
      exp = 4'b0000;
      n_compared++;
      if (got !== exp) begin
        n_mismatched++;
        $display("FAIL reset_pending_short cycle %0d: got {S,L,D,H}=%b, want %b", c, got, exp);
      end
      i_Rst_L  = (c != 6);
      i_Switch = (c < 3);
    end
  endtask

  initial begin
    n_compared   = 0;
    n_mismatched = 0;
    i_Rst_L      = 1'b0;
    i_Switch     = 1'b0;
    test_reset();
    test_short_press();
    test_long_press();
    test_double_press();
    test_gap_expiry_edge();
    test_gap_just_missed();
    test_reset_mid_press();
    test_reset_pending_short();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule : tb_press_classifier

`default_nettype wire
